// File: rtl/inst_loader.sv
// Boot-time instruction-memory loader: 2-byte big-endian word count N, then N
// big-endian 32-bit words, each written to BASE_ADDR + 4*index.
// Latency: the write strobe follows the 4th byte of a word by one cycle; done follows the last write by one cycle.
// Backpressure: byte_ready is low in IDLE, WRITE, DONE and ERR; the source may stall byte_valid indefinitely.
//
// Ports: clk, rst_n (async active-low); start request; byte_valid/byte_ready/byte_data
// stream input; mem_we/mem_addr/mem_din write port; cpu_hold, done, err, word_count status.
// Optional macro INST_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module inst_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_din,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
`ifdef INST_LOADER_CHECKSUM_EN
        CHK   = 3'd6,
`endif
        ERR   = 3'd5
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t           state, state_nx;
    logic [1:0]       idx, idx_nx;
    logic [7:0]       hdr_hi, hdr_hi_nx;
    logic [CNT_W-1:0] n_words, n_words_nx;
    logic [23:0]      word, word_nx;
    logic [CNT_W-1:0] wc_nx, wc_inc;
    logic [31:0]      addr_nx, din_nx;
    logic [15:0]      hdr_val;
    logic             accept;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]       xsum, xsum_nx;
`endif

    assign accept  = byte_valid && byte_ready;
    assign hdr_val = {hdr_hi, byte_data};
    assign wc_inc  = word_count + CNT_W'(1);

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        hdr_hi_nx  = hdr_hi;
        n_words_nx = n_words;
        word_nx    = word;
        wc_nx      = word_count;
        addr_nx    = mem_addr;
        din_nx     = mem_din;
`ifdef INST_LOADER_CHECKSUM_EN
        xsum_nx    = xsum;
`endif
        case (state)
            IDLE, ERR: begin
                if (start) begin
                    state_nx = HDR;
                    idx_nx   = 2'd0;
                    wc_nx    = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    xsum_nx  = 8'h00;
`endif
                end
            end
            HDR: begin
                if (accept) begin
                    if (idx == 2'd0) begin
                        hdr_hi_nx = byte_data;
                        idx_nx    = 2'd1;
                    end else begin
                        idx_nx     = 2'd0;
                        n_words_nx = CNT_W'(hdr_val);
                        if (hdr_val == 16'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            state_nx = CHK;
`else
                            state_nx = DONE;
`endif
                        end else if ({1'b0, hdr_val} > DEPTH_L) begin
                            state_nx = ERR;
                        end else begin
                            state_nx = LOAD;
                        end
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    word_nx = {word[15:0], byte_data};
                    idx_nx  = idx + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                    xsum_nx = xsum ^ byte_data;
`endif
                    if (idx == 2'd3) begin
                        // Capture the full word and its address on entry to WRITE
                        // so both are stable for the whole strobe cycle.
                        state_nx = WRITE;
                        din_nx   = {word, byte_data};
                        addr_nx  = BASE_ADDR + (32'(word_count) << 2);
                    end
                end
            end
            WRITE: begin
                wc_nx = wc_inc;
                if (wc_inc == n_words) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    state_nx = CHK;
`else
                    state_nx = DONE;
`endif
                end else begin
                    state_nx = LOAD;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_nx = (byte_data == xsum) ? DONE : ERR;
                end
            end
`endif
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // All outputs are registered and decoded from the next state, so each
    // output changes on the same edge as the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            hdr_hi     <= 8'h00;
            n_words    <= '0;
            word       <= 24'h0;
            word_count <= '0;
            mem_addr   <= 32'h0;
            mem_din    <= 32'h0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            xsum       <= 8'h00;
`endif
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            hdr_hi     <= hdr_hi_nx;
            n_words    <= n_words_nx;
            word       <= word_nx;
            word_count <= wc_nx;
            mem_addr   <= addr_nx;
            mem_din    <= din_nx;
`ifdef INST_LOADER_CHECKSUM_EN
            xsum       <= xsum_nx;
            byte_ready <= (state_nx == HDR) || (state_nx == LOAD) || (state_nx == CHK);
`else
            byte_ready <= (state_nx == HDR) || (state_nx == LOAD);
`endif
            mem_we     <= (state_nx == WRITE);
            cpu_hold   <= (state_nx != IDLE);
            done       <= (state_nx == DONE);
            err        <= (state_nx == ERR);
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    inst_loader #(.BASE_ADDR(32'h0), .DEPTH(256), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] din;
    } wr_t;

    wr_t         wr_q[$];
    int          done_q[$];
    wr_t         exp_wr;
    int          exp_wc;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_writes = 0;
    logic [31:0] prog [0:7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops expected writes / completions whenever the DUT presents them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                n_writes++;
                check("write_ready_low", byte_ready, 1'b0);
                check("write_expected", wr_q.size() != 0, 1'b1);
                if (wr_q.size() != 0) begin
                    exp_wr = wr_q.pop_front();
                    check("write_addr", mem_addr, exp_wr.addr);
                    check("write_data", mem_din, exp_wr.din);
                end
            end
            if (done) begin
                check("done_expected", done_q.size() != 0, 1'b1);
                if (done_q.size() != 0) begin
                    exp_wc = done_q.pop_front();
                    check("done_word_count", word_count, exp_wc);
                end
            end
        end
    end

    // All drives happen 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        @(negedge clk);
        while (!byte_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        check("byte_accepted", byte_ready, 1'b1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 100) begin
            t++;
            @(negedge clk);
        end
        check("done_seen", done, 1'b1);
        @(posedge clk);
        #1;
        check("hold_released", cpu_hold, 1'b0);
    endtask

    // Loads prog[0:n-1] at word index 0 onwards; gaps up to maxgap idle cycles per byte.
    task automatic run_load(input int n, input int maxgap, input bit do_start);
        logic [7:0] xs;
        logic [15:0] nh;
        xs = 8'h00;
        nh = 16'(n);
        if (do_start) pulse_start();
        done_q.push_back(n);
        send_byte(nh[15:8], 0);
        send_byte(nh[7:0], 0);
        check("hold_while_loading", cpu_hold, 1'b1);
        for (int w = 0; w < n; w++) begin
            wr_q.push_back('{addr: 32'(w) << 2, din: prog[w]});
            for (int b = 0; b < 4; b++) begin
                xs = xs ^ prog[w][31-8*b -: 8];
                send_byte(prog[w][31-8*b -: 8], int'($urandom_range(0, maxgap)));
            end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(xs, 0);
`endif
        wait_done();
    endtask

    int wr_before;

    initial begin
        #1;
        check("rst_flags", {byte_ready, mem_we, cpu_hold, done, err}, 5'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_din", mem_din, 32'h0);
        check("rst_wc", word_count, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single word DEADBEEF with exact latency
        pulse_start();
        check("t1_ready_in_hdr", byte_ready, 1'b1);
        done_q.push_back(1);
        wr_q.push_back('{addr: 32'h0, din: 32'hDEADBEEF});
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(8'h22, 0);
        wait_done();
`else
        check("t1_we_latency", mem_we, 1'b1);
        @(posedge clk);
        #1;
        check("t1_done_latency", done, 1'b1);
        check("t1_we_single", mem_we, 1'b0);
        @(posedge clk);
        #1;
        check("t1_hold_fall", cpu_hold, 1'b0);
        check("t1_done_pulse", done, 1'b0);
`endif
        check("t1_word_count", word_count, 16'd1);

        // 2: three words with random valid gaps
        prog[0] = 32'h01020304;
        prog[1] = 32'hA5A55A5A;
        prog[2] = 32'h80FF7F00;
        wr_before = n_writes;
        run_load(3, 3, 1'b1);
        check("t2_write_pulses", n_writes - wr_before, 3);
        check("t2_word_count", word_count, 16'd3);

        // 3: empty program
        wr_before = n_writes;
        pulse_start();
        done_q.push_back(0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`else
        check("t3_done_latency", done, 1'b1);
`endif
        wait_done();
        check("t3_no_writes", n_writes - wr_before, 0);
        check("t3_word_count", word_count, 16'd0);

        // 4: oversize header, then recovery
        wr_before = n_writes;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("t4_err", err, 1'b1);
        check("t4_hold", cpu_hold, 1'b1);
        check("t4_ready_low", byte_ready, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("t4_err_sticky", {err, cpu_hold}, 2'b11);
        check("t4_no_writes", n_writes - wr_before, 0);
        pulse_start();
        check("t4_err_cleared", err, 1'b0);
        prog[0] = 32'hCAFEF00D;
        run_load(1, 0, 1'b0);
        check("t4_word_count", word_count, 16'd1);

        // 5: asynchronous reset mid-word
        wr_before = n_writes;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_flags", {byte_ready, mem_we, cpu_hold, done, err}, 5'b0);
        check("t5_rst_addr", mem_addr, 32'h0);
        check("t5_rst_din", mem_din, 32'h0);
        check("t5_rst_wc", word_count, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t5_no_writes", n_writes - wr_before, 0);
        prog[0] = 32'h0BADC0DE;
        prog[1] = 32'h13579BDF;
        run_load(2, 1, 1'b1);
        check("t5_word_count", word_count, 16'd2);

`ifdef INST_LOADER_CHECKSUM_EN
        // 6: checksum match (0x08) and mismatch (0x09)
        pulse_start();
        done_q.push_back(1);
        wr_q.push_back('{addr: 32'h0, din: 32'h12345678});
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        send_byte(8'h08, 0);
        wait_done();
        wr_before = n_writes;
        pulse_start();
        wr_q.push_back('{addr: 32'h0, din: 32'h12345678});
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        send_byte(8'h09, 0);
        check("t6_err", {err, cpu_hold}, 2'b11);
        check("t6_written", n_writes - wr_before, 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("end_writes_drained", wr_q.size(), 0);
        check("end_done_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time writer for the instruction memory. The CPU only ever reads that memory, fetching at pc_out.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Writes each word to consecutive word addresses through a single-cycle write strobe.
- Holds the CPU in reset-equivalent stall (cpu_hold) while a program is loading.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written; must be 4-aligned.
- DEPTH, 256, maximum number of words accepted; the instruction memory size in words.
- CNT_W, 16, width of the word-count header and of word_count.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load; sampled in IDLE and ERR only.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready at a rising edge.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  32  byte address for the write, BASE_ADDR + 4*index.
- mem_din  output  32  assembled instruction word.
- cpu_hold  output  1  high while loading or in error; CPU must not fetch.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky error flag.
- word_count  output  CNT_W  words written so far in the current load.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. All outputs are 0, including mem_addr = 0, mem_din = 0 and word_count = 0. A partially assembled word is discarded and no write is issued.
- Stream format: 2-byte header N (MSB first), then N words of 4 bytes each, MSB first (byte0 = bits 31:24).
- FSM states: IDLE, HDR, LOAD, WRITE, CHK (optional feature only), DONE, ERR.
- IDLE:
  - byte_ready = 0, cpu_hold = 0.
  - start moves to HDR, clears word_count and the byte index, and clears err.
- HDR:
  - byte_ready = 1, cpu_hold = 1.
  - After the 2nd header byte: N == 0 goes to DONE; N > DEPTH goes to ERR; otherwise goes to LOAD.
- LOAD:
  - byte_ready = 1.
  - Shifts accepted bytes into the word register.
  - The 4th accepted byte moves to WRITE.
- WRITE:
  - Lasts exactly one cycle with byte_ready = 0.
  - mem_we = 1, mem_addr = BASE_ADDR + 4*word_count, mem_din = assembled word.
  - word_count increments on the same edge that leaves WRITE.
  - When word_count+1 == N, moves to DONE (or CHK); otherwise moves to LOAD.
- DONE:
  - done = 1 for one cycle, then IDLE.
  - cpu_hold drops on entry to IDLE.
- ERR:
  - err = 1 and cpu_hold = 1 until start or reset; byte_ready = 0.
  - start restarts the load by moving to HDR.
- start asserted in HDR, LOAD, WRITE or DONE is ignored.
- mem_addr and mem_din hold their last written values outside WRITE.
- Latency:
  - Final payload byte accepted at edge k: mem_we is high in the cycle after edge k, and done is high in the following cycle.
  - Minimum cost is 5 cycles per word (4 byte cycles plus 1 write cycle).
- byte_valid may drop at any time; the loader simply waits with no timeout.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE the FSM enters CHK with byte_ready = 1.
  - It accepts one trailing byte and compares it with the XOR of all payload bytes (header excluded).
  - Match goes to DONE; mismatch goes to ERR. Words already written remain in memory.
  - With N == 0, the trailing byte must be 8'h00.
- Undefined: the CHK state and the XOR register do not exist, and no trailing byte is consumed.

Test Plan:
1. start; stream 00 01 DE AD BE EF:
   - one mem_we pulse with mem_addr = 0x0 and mem_din = 0xDEADBEEF;
   - done pulses one cycle later;
   - cpu_hold falls the next cycle; word_count = 1.
2. N = 3, random byte_valid gaps:
   - writes at 0x0, 0x4 and 0x8 with the words in stream order;
   - byte_ready = 0 in every WRITE cycle;
   - exactly 3 mem_we pulses and final word_count = 3.
3. Stream 00 00:
   - no mem_we;
   - done pulses the cycle after the 2nd header byte is accepted.
4. Header 01 01 (257 > DEPTH):
   - err = 1, cpu_hold stays 1 and no writes occur;
   - a following start clears err, and a valid load then completes.
5. rst_n pulsed low after 2 payload bytes of word 0:
   - all outputs are 0 immediately, asynchronously, with no mem_we;
   - a later start with a full stream loads correctly from 0x0.
6. With INST_LOADER_CHECKSUM_EN, payload 12 34 56 78:
   - trailing byte 0x08 gives done;
   - trailing byte 0x09 gives err = 1 after the word at 0x0 has been written.
